// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter and sequencer for a shared W-bit preset/clear register.
// Each granted requester gets one operation (load, preset, clear, reserved)
// committed to the shared register, followed by a one-cycle grant pulse.
// All state updates on the falling edge of clk; clr is an async active-high reset.
module ff_bank_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N-1:0]      req,
  input  logic [2*N-1:0]    op,
  input  logic [W*N-1:0]    d,
  output logic [W-1:0]      q,
  output logic [N-1:0]      gnt,
  output logic [IW-1:0]     owner,
  output logic              busy,
  output logic              err
);

  localparam logic StIdle   = 1'b0;
  localparam logic StCommit = 1'b1;

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpPreset = 2'b01;
  localparam logic [1:0] OpClear  = 2'b10;
  localparam logic [1:0] OpRsvd   = 2'b11;

  logic          state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [1:0]    op_cap_q, op_cap_d;
  logic [W-1:0]  d_cap_q, d_cap_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          err_q, err_d;

  logic [1:0]    op_arr [N];
  logic [W-1:0]  d_arr  [N];
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;

  // Split the flat per-requester buses into indexable slices.
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign op_arr[g] = op[2*g +: 2];
    assign d_arr[g]  = d[W*g +: W];
  end

  // Pick the first requester at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_q) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state: capture in IDLE, apply and pulse grant in COMMIT.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_cap_d = op_cap_q;
    d_cap_d  = d_cap_q;
    q_d      = q_q;
    gnt_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StCommit;
          owner_d  = win;
          op_cap_d = op_arr[win];
          d_cap_d  = d_arr[win];
        end
      end
      StCommit: begin
        case (op_cap_q)
          OpLoad:   q_d = d_cap_q;
          OpPreset: q_d = '1;
          OpClear:  q_d = '0;
          default:  q_d = q_q;
        endcase
        for (int unsigned i = 0; i < N; i++) begin
          gnt_d[i] = (owner_q == IW'(i));
        end
        err_d   = (op_cap_q == OpRsvd);
        // Winner drops to lowest priority for the next round.
        ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; clr discards any operation in flight.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_cap_q <= '0;
      d_cap_q  <= '0;
      q_q      <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_cap_q <= op_cap_d;
      d_cap_q  <= d_cap_d;
      q_q      <= q_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
    end
  end

  assign q     = q_q;
  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q == StCommit);
  assign err   = err_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter: directed scenarios plus random traffic, checked
// by a transaction-level reference model feeding a scoreboard queue.
module tb_ff_bank_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  op  = '0;
  logic [W*N-1:0]  d   = '0;
  logic [W-1:0]    q;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   owner;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] gnt;
    int           owner;
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  exp_t sb[$];

  // Reference model state (transaction level).
  logic         m_busy   = 1'b0;
  int           m_ptr    = 0;
  int           m_win    = 0;
  logic [W-1:0] m_q      = '0;
  logic [W-1:0] m_next_q = '0;

  ff_bank_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk   (clk),
    .clr   (clr),
    .req   (req),
    .op    (op),
    .d     (d),
    .q     (q),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int idx, input logic [1:0] opc, input logic [W-1:0] dat);
    op[2*idx +: 2] = opc;
    d[W*idx +: W]  = dat;
  endtask

  // Issue one request and wait (bounded) for its grant.
  task automatic do_op(input int idx, input logic [1:0] opc, input logic [W-1:0] dat,
                       output logic [N-1:0] g, output logic [W-1:0] qv, output logic e,
                       output logic [IW-1:0] ow);
    g = '0; qv = '0; e = 1'b0; ow = '0;
    @(posedge clk); #1;
    set_slot(idx, opc, dat);
    req[idx] = 1'b1;
    for (int c = 0; c < 10 && g == '0; c++) begin
      @(posedge clk);
      if (gnt != '0) begin
        g = gnt; qv = q; e = err; ow = owner;
      end
    end
    #1 req[idx] = 1'b0;
  endtask

  // Model: arbitrate and commit on falling edges using the rules directly.
  initial begin
    forever begin
      @(negedge clk or posedge clr);
      if (clr) begin
        m_busy = 1'b0; m_ptr = 0; m_q = '0; m_next_q = '0;
        sb.delete();
      end else if (m_busy) begin
        m_busy = 1'b0;
        m_q    = m_next_q;
        m_ptr  = (m_win + 1) % N;
      end else if (req != '0) begin
        int   idx;
        int   opc;
        logic [W-1:0] dat;
        exp_t ex;
        idx = -1;
        for (int k = 0; k < N; k++) begin
          if (idx < 0 && req[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
        end
        opc = int'(op >> (2 * idx)) & 3;
        dat = W'(d >> (W * idx));
        case (opc)
          0:       m_next_q = dat;
          1:       m_next_q = '1;
          2:       m_next_q = '0;
          default: m_next_q = m_q;
        endcase
        m_win    = idx;
        m_busy   = 1'b1;
        ex.gnt   = N'(1) << idx;
        ex.owner = idx;
        ex.q     = m_next_q;
        ex.err   = (opc == 3);
        sb.push_back(ex);
      end
    end
  end

  // Monitor: compare outputs every rising edge, pop scoreboard on grants.
  initial begin
    forever begin
      @(posedge clk);
      if (!clr) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("q", 32'(q), 32'(m_q));
        if (gnt != '0) begin
          if (sb.size() == 0) begin
            check("gnt_unexpected", 32'(gnt), 32'd0);
          end else begin
            exp_t ex;
            ex = sb.pop_front();
            check("gnt", 32'(gnt), 32'(ex.gnt));
            check("owner", 32'(owner), 32'(ex.owner));
            check("q_at_gnt", 32'(q), 32'(ex.q));
            check("err", 32'(err), 32'(ex.err));
          end
        end else begin
          check("err_idle", 32'(err), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]  g;
    logic [W-1:0]  qv;
    logic          e;
    logic [IW-1:0] ow;
    int            rr_idx [5];
    int            rr_cyc [5];
    int            n_rr;
    int            cyc;

    // Reset values.
    repeat (3) @(posedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Reset mid-COMMIT discards a captured load of 4'hA.
    #1 clr = 1'b0;
    set_slot(2, 2'b00, 4'hA);
    req = 4'b0100;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    #1;
    check("clr_q", 32'(q), 32'd0);
    check("clr_gnt", 32'(gnt), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      check("no_late_A", 32'(q), 32'd0);
    end

    // Single load.
    do_op(2, 2'b00, 4'h9, g, qv, e, ow);
    check("load_gnt", 32'(g), 32'b0100);
    check("load_q", 32'(qv), 32'h9);
    check("load_owner", 32'(ow), 32'd2);
    @(posedge clk);
    check("gnt_one_cycle", 32'(gnt), 32'd0);
    check("owner_hold", 32'(owner), 32'd2);

    // Preset then clear.
    do_op(0, 2'b01, 4'h0, g, qv, e, ow);
    check("preset_gnt", 32'(g), 32'b0001);
    check("preset_q", 32'(qv), 32'hF);
    do_op(1, 2'b10, 4'h7, g, qv, e, ow);
    check("clear_gnt", 32'(g), 32'b0010);
    check("clear_q", 32'(qv), 32'h0);

    // Reserved op leaves q and raises err with the grant.
    do_op(2, 2'b00, 4'h5, g, qv, e, ow);
    check("pre_rsvd_q", 32'(qv), 32'h5);
    do_op(3, 2'b11, 4'hE, g, qv, e, ow);
    check("rsvd_gnt", 32'(g), 32'b1000);
    check("rsvd_q", 32'(qv), 32'h5);
    check("rsvd_err", 32'(e), 32'd1);

    // Data change during COMMIT does not affect the operation in flight.
    @(posedge clk); #1;
    set_slot(1, 2'b00, 4'h3);
    req[1] = 1'b1;
    @(posedge clk); #1;
    d[W*1 +: W] = 4'hC;
    g = '0;
    for (int c = 0; c < 6 && g == '0; c++) begin
      @(posedge clk);
      if (gnt != '0) begin g = gnt; qv = q; end
    end
    #1 req = '0;
    check("late_gnt", 32'(g), 32'b0010);
    check("late_q", 32'(qv), 32'h3);

    // Round-robin from a fresh pointer with all four requesting loads.
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 2'b00, W'(i + 1));
    req = 4'b1111;
    n_rr = 0;
    cyc  = 0;
    for (int i = 0; i < 5; i++) begin rr_idx[i] = -1; rr_cyc[i] = -100; end
    while (n_rr < 5 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      if (gnt != '0) begin
        for (int j = 0; j < N; j++) if (gnt[j]) rr_idx[n_rr] = j;
        rr_cyc[n_rr] = cyc;
        n_rr++;
      end
    end
    #1 req = '0;
    for (int k = 0; k < 5; k++) check("rr_order", 32'(rr_idx[k]), 32'(k % N));
    for (int k = 1; k < 5; k++) check("rr_spacing", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd2);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (clr) clr = 1'b0;
      else if ($urandom_range(0, 99) == 0) clr = 1'b1;
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      op  = (2*N)'($urandom);
      d   = (W*N)'($urandom);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    req = '0;
    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

Round-robin arbiter and sequencer for a shared W-bit register built from D flip-flops with preset/clear semantics. Up to N requesters each ask for one operation on the shared register: load data, preset (all ones), clear (all zeros) or reserved. The arbiter grants one requester at a time, commits its operation and pulses a grant back. It sits between the control units that own the requesters and the shared storage register; `q` is the register content.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `W`, default 4: width of the shared register.
- `IW`, default `$clog2(N)`: width of the owner index.

- `clk`  in  1  clock; all state updates on the falling edge, matching the flip-flops it drives.
- `clr`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester request, level-sensitive.
- `op`   in  2·N  per-requester opcode; slice i is bits [2i+1:2i]. Codes: 00 load, 01 preset, 10 clear, 11 reserved.
- `d`    in  W·N  per-requester load data; slice i is bits [W·i+W-1:W·i].
- `q`    out  W  shared register content.
- `gnt`  out  N  one-hot grant pulse, one cycle long.
- `owner`  out  IW  index of the requester being serviced.
- `busy`  out  1  high while in state COMMIT.
- `err`   out  1  one-cycle pulse when a reserved opcode is committed.

## Operation
- States: IDLE, COMMIT.
- Round-robin pointer `ptr` (IW bits) gives the highest-priority index. It wraps from N-1 to 0.

**IDLE**
- Hold `gnt` = 0 and `err` = 0.
- If any `req` bit is high, select the first set bit scanning `ptr`, `ptr`+1, … modulo N.
- On that edge, capture the winner index into `owner`, and the winner's `op` and `d` slices into internal registers.
- Go to COMMIT.
- If no `req` bit is high, stay in IDLE and leave `q` unchanged.

**COMMIT**
- Apply the captured op to `q` on the next edge:
  - 00: `q` ← captured d.
  - 01: `q` ← all ones.
  - 10: `q` ← all zeros.
  - 11: `q` unchanged, and `err` pulses high for one cycle.
- On the same edge, `gnt[owner]` pulses high, `ptr` ← `owner`+1 modulo N, and the state returns to IDLE.

**Rules**
- Op and data are sampled only at arbitration. Changes to `req`, `op` or `d` during COMMIT do not affect the operation in flight.
- A requester that keeps `req` high after its `gnt` takes part in the next arbitration with the lowest priority. Because `ptr` has moved past it, other waiting requesters win first.
- Exactly one `gnt` bit is high at a time. `gnt` and `err` are never high outside the cycle that follows a commit edge.
- `busy` = 1 exactly while in COMMIT.
- `owner` holds its value in IDLE until the next arbitration.

**Reset**
- `clr` high, asynchronously and at any time including during COMMIT, forces: `q` = 0, `gnt` = 0, `owner` = 0, `busy` = 0, `err` = 0, `ptr` = 0, state IDLE.
- An operation that is in flight is discarded and never granted.
- After `clr` falls, the first falling edge may arbitrate.

## Timing
- Edges below mean falling edges of `clk`.
- Request to grant latency: `req` seen at edge k → `q` updated and `gnt` high during the cycle after edge k+1.
- Throughput: one operation per 2 cycles while requests are pending.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Worst-case wait for a continuously requesting master: 2·N cycles.

## Test plan
1. Reset: assert `clr` mid-COMMIT with a captured load of d=4'hA → `q`=0, `gnt`=0, `busy`=0 immediately, and `q` never becomes 4'hA.
2. Single load: `req`=4'b0100, op[5:4]=00, d slice 2 = 4'h9 → after 2 edges `q`=4'h9, `gnt`=4'b0100 for one cycle, `owner`=2.
3. Preset and clear: requester 0 presets, then requester 1 clears → `q`=4'hF, then 4'h0. Grants go 0001 then 0010.
4. Round-robin: `req`=4'b1111 held constant with all loads → grant order 0,1,2,3,0, one grant every 2 cycles, and `ptr` wraps 3→0.
5. Reserved op: requester 3 with op=11 and `q`=4'h5 → `q` stays 4'h5, `err` pulses coincident with `gnt`=4'b1000.
6. Late change: requester 1 changes d from 4'h3 to 4'hC during COMMIT → `q`=4'h3.
